// File: rtl/dual_ram_pkg.sv
// Shared definitions for the byte-enable RAM with sequenced clear.
// Holds the clear-FSM state encoding and the byte-lane width.
package dual_ram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dual_ram_clr_seq.sv
// Clear sequencer: walks a pointer over every word and raises a clear strobe.
// The sequencer is busy from reset and after each accepted clr request,
// for exactly DEPTH cycles. A clr request that arrives while busy is ignored.
module dual_ram_clr_seq
    import dual_ram_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ADDR_BUS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    output logic [ADDR_BUS-1:0] clr_addr,
    output logic                clr_we
);

    localparam logic [ADDR_BUS-1:0] LAST_PTR = ADDR_BUS'(DEPTH - 1);
    localparam logic [ADDR_BUS-1:0] PTR_ONE  = ADDR_BUS'(1'b1);

    clr_state_e          state_r;
    clr_state_e          state_s;
    logic [ADDR_BUS-1:0] ptr_r;
    logic [ADDR_BUS-1:0] ptr_s;

    // State and pointer registers; reset starts a fresh clear from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_BUS{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next-state logic: advance the pointer while clearing, stop after the last word.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == LAST_PTR) begin
                    state_s = ST_IDLE;
                    ptr_s   = {ADDR_BUS{1'b0}};
                end else begin
                    state_s = ST_CLEAR;
                    ptr_s   = ptr_r + PTR_ONE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_s = ST_CLEAR;
                    ptr_s   = {ADDR_BUS{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    ptr_s   = ptr_r;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = {ADDR_BUS{1'b0}};
            end
        endcase
    end

    assign busy     = (state_r == ST_CLEAR) ? 1'b1 : 1'b0;
    assign clr_we   = (state_r == ST_CLEAR) ? 1'b1 : 1'b0;
    assign clr_addr = ptr_r;

endmodule

// File: rtl/dual_ram_be_clr.sv
// Single-clock RAM with byte-lane writes, a registered read port and a
// sequenced whole-array clear. Out-of-range accesses raise a one-cycle err.
// Optional feature: define DUAL_RAM_BYPASS_EN to forward same-cycle write
// lanes into a colliding read. Without it a collision returns the old word.
module dual_ram_be_clr
    import dual_ram_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_BUS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [WIDTH/8-1:0]  be,
    input  logic [ADDR_BUS-1:0] wr_addr,
    input  logic [WIDTH-1:0]    din,
    input  logic                re,
    input  logic [ADDR_BUS-1:0] rd_addr,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic                busy,
    output logic                err
);

    localparam int                LANES     = WIDTH / LANE_W;
    localparam logic [ADDR_BUS:0] DEPTH_LIM = (ADDR_BUS + 1)'(DEPTH);

    // Array contents carry no reset; the clear sequence establishes zeros.
    logic [WIDTH-1:0]    mem_r [DEPTH];

    logic                busy_s;
    logic                clr_we_s;
    logic [ADDR_BUS-1:0] clr_addr_s;
    logic                wr_in_range_s;
    logic                rd_in_range_s;
    logic                wr_ok_s;
    logic                rd_ok_s;
    logic                err_s;
    logic [WIDTH-1:0]    old_word_s;
    logic [WIDTH-1:0]    rd_word_s;
    logic [WIDTH-1:0]    dout_r;
    logic                dout_valid_r;
    logic                err_r;

`ifdef DUAL_RAM_BYPASS_EN
    // Take lanes flagged in lane_en from new_w, the rest from old_w.
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [LANES-1:0] lane_en
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < LANES; k++) begin
            if (lane_en[k]) begin
                res[k*LANE_W +: LANE_W] = new_w[k*LANE_W +: LANE_W];
            end else begin
                res[k*LANE_W +: LANE_W] = old_w[k*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction
`endif

    dual_ram_clr_seq #(
        .DEPTH    (DEPTH),
        .ADDR_BUS (ADDR_BUS)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );

    // Access qualification: clr wins over a same-cycle write, reads still proceed.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_LIM) ? 1'b1 : 1'b0;
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_LIM) ? 1'b1 : 1'b0;
        wr_ok_s       = we & ~busy_s & ~clr & wr_in_range_s;
        rd_ok_s       = re & ~busy_s & rd_in_range_s;
        err_s         = ~busy_s & ((we & ~wr_in_range_s) | (re & ~rd_in_range_s));
    end

    // Read word selection, with optional forwarding of same-address write lanes.
    always_comb begin
        old_word_s = {WIDTH{1'b0}};
        if (rd_in_range_s) begin
            old_word_s = mem_r[rd_addr];
        end else begin
            old_word_s = {WIDTH{1'b0}};
        end
        rd_word_s = old_word_s;
`ifdef DUAL_RAM_BYPASS_EN
        if (wr_ok_s && (wr_addr == rd_addr)) begin
            rd_word_s = merge_lanes(old_word_s, din, be);
        end else begin
            rd_word_s = old_word_s;
        end
`endif
    end

    // Array update: the clear strobe and user writes are mutually exclusive via busy.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= {WIDTH{1'b0}};
        end else if (wr_ok_s) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k]) begin
                    mem_r[wr_addr][k*LANE_W +: LANE_W] <= din[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read data, valid pulse and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            dout_valid_r <= rd_ok_s;
            err_r        <= err_s;
            if (rd_ok_s) begin
                dout_r <= rd_word_s;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign err        = err_r;
    assign busy       = busy_s;

endmodule

// File: doc/dual_ram_be_clr.md
DUAL_RAM_BE_CLR -- requirements
Module: dual_ram_be_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of words; minimum 2.
REQ-003 SHALL have parameter ADDR_BUS, default 3, address width; legal only when 2**ADDR_BUS >= DEPTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clr, input, 1, synchronous request to zero the whole array.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port be, input, WIDTH/8, byte-lane write enables; bit k covers din[8k+7:8k].
REQ-009 SHALL have port wr_addr, input, ADDR_BUS, write address.
REQ-010 SHALL have port din, input, WIDTH, write data.
REQ-011 SHALL have port re, input, 1, read enable.
REQ-012 SHALL have port rd_addr, input, ADDR_BUS, read address.
REQ-013 SHALL have port dout, output, WIDTH, registered read data.
REQ-014 SHALL have port dout_valid, output, 1, one-cycle pulse marking fresh dout.
REQ-015 SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on an out-of-range access.

Function
REQ-017 SHALL implement a clear FSM with two states: CLEAR (zero mem[ptr], increment ptr each cycle) and IDLE; CLEAR goes to IDLE after writing ptr = DEPTH-1.
REQ-018 SHALL drive busy high in CLEAR and low in IDLE; a full clear occupies exactly DEPTH cycles.
REQ-019 SHALL enter CLEAR with ptr = 0 on the edge after clr is sampled high in IDLE; clr while busy is ignored.
REQ-020 SHALL ignore we and re while busy: no array update, dout_valid = 0, err = 0.
REQ-021 SHALL, when we = 1, not busy and wr_addr < DEPTH, update only the lanes with be[k] = 1 at the edge; be = 0 writes nothing.
REQ-022 SHALL, when re = 1, not busy and rd_addr < DEPTH, load dout from mem[rd_addr] at the edge and pulse dout_valid for one cycle; latency 1 clock.
REQ-023 SHALL hold dout unchanged whenever no valid read occurs.
REQ-024 SHALL, on an enabled write or read whose address is >= DEPTH while not busy, perform no array update and no dout update, and pulse err for one cycle.
REQ-025 SHALL give clr priority over a same-cycle we; that write is dropped.
REQ-026 SHALL give a same-cycle re in the clr cycle its normal read; reads are blocked from the next cycle while busy.
REQ-027 SHALL, when a read and a write target the same address in the same cycle, return the pre-write word unless REQ-031 applies.

Reset
REQ-028 SHALL on rst: dout = 0, dout_valid = 0, err = 0, busy = 1, state CLEAR, ptr = 0.
REQ-029 SHALL restart the clear from ptr = 0 after rst is asserted mid-clear.
REQ-030 SHALL leave array contents undefined during rst and reach all-zero only through the clear sequence after release.

Configuration
REQ-031 SHALL, with macro DUAL_RAM_BYPASS_EN defined, return the merged word on a same-address read/write collision: lanes with be = 1 from din, the other lanes from the old word. Without the macro, REQ-027 holds and the bypass logic SHALL be absent.

Structure
REQ-032 SHALL place the FSM state encoding (CLEAR, IDLE) and the lane-width constant 8 in the package dual_ram_pkg.
REQ-033 SHALL implement the clear FSM and pointer as sub-module dual_ram_clr_seq (outputs busy, clear address, clear write strobe).

Verification (WIDTH=16, DEPTH=8, ADDR_BUS=3)
REQ-034 Release rst -> busy high for exactly 8 cycles; a read of each address afterwards returns 16'h0000 with a dout_valid pulse each.
REQ-035 Write 16'hABCD with be=2'b11 to addr 3, then write 16'h1200 with be=2'b10 to addr 3, then read addr 3 -> dout = 16'h12CD one cycle after re.
REQ-036 Same cycle: write 16'h5555 (be=2'b01) to addr 2, which holds 16'hAAAA, and read addr 2 -> 16'hAAAA without the macro, 16'hAA55 with DUAL_RAM_BYPASS_EN.
REQ-037 we at wr_addr=3'd7 succeeds; with DEPTH=6, we/re at address 6 or 7 -> err pulse, no array or dout change.
REQ-038 clr and we in the same cycle -> write dropped, busy for 8 cycles, every address reads 0; re while busy -> dout_valid stays 0.
REQ-039 Assert rst at clear cycle 4 -> after release, busy again lasts a full 8 cycles.
